// File: rtl/jmp_issue_queue.sv
// rtl/jmp_issue_queue.sv - collapsing oldest-first issue queue for the jump/branch pipe
// Optional JMP_IQ_PERF_EN adds stall_cycles/issued_cnt performance counters.
module jmp_issue_queue #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_iq,
    input  logic          dispatch_valid,
    output logic          dispatch_ready,
    input  logic [5:0]    dispatch_pos,
    input  logic [5:0]    dispatch_prd,
    input  logic [5:0]    dispatch_prs1,
    input  logic [5:0]    dispatch_prs2,
    input  logic          dispatch_prs1_valid,
    input  logic          dispatch_prs2_valid,
    input  logic          dispatch_prs1_ready,
    input  logic          dispatch_prs2_ready,
    input  logic [2:0]    dispatch_funct3,
    input  logic [6:0]    dispatch_funct7,
    input  logic [4:0]    dispatch_rs1,
    input  logic [4:0]    dispatch_rs2,
    input  logic [4:0]    dispatch_rd,
    input  logic [31:0]   dispatch_pc,
    input  logic          alu_wake_valid,
    input  logic [5:0]    alu_wake_prd,
    input  logic          jmp_wake_valid,
    input  logic [5:0]    jmp_wake_prd,
    input  logic          wb_wake_valid,
    input  logic [5:0]    wb_wake_prd,
    output logic          req_issue,
    output logic [5:0]    pos_issue,
    output logic [5:0]    prd_issue,
    output logic [5:0]    prs1_issue,
    output logic [5:0]    prs2_issue,
    output logic          prs1_valid_issue,
    output logic          prs2_valid_issue,
    output logic [2:0]    funct3_issue,
    output logic [6:0]    funct7_issue,
    output logic [4:0]    rs1_issue,
    output logic [4:0]    rs2_issue,
    output logic [4:0]    rd_issue,
    output logic [31:0]   pc_issue,
    output logic          alubypass1_issue,
    output logic          alubypass2_issue,
    output logic          jmpbypass1_issue,
    output logic          jmpbypass2_issue,
    output logic [CW-1:0] iq_count
`ifdef JMP_IQ_PERF_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   issued_cnt
`endif
);

    typedef struct packed {
        logic [5:0]  pos;
        logic [5:0]  prd;
        logic [5:0]  prs1;
        logic [5:0]  prs2;
        logic        p1v;
        logic        p2v;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        rdy1;
        logic        rdy2;
    } entry_t;

    logic [DEPTH-1:0] vld, vld_n;
    entry_t           ent   [DEPTH];
    entry_t           upd   [DEPTH];
    entry_t           ent_n [DEPTH];
    logic [CW-1:0]    count, cnt_rm, count_n;

    logic [DEPTH-1:0] m1a, m1j, m1w, m2a, m2j, m2w, elig;
    logic             any_elig, accept;
    logic [IW-1:0]    sel;
    entry_t           s_ent, new_e;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            m1a[i] = ent[i].p1v && !ent[i].rdy1 && alu_wake_valid && (alu_wake_prd == ent[i].prs1);
            m1j[i] = ent[i].p1v && !ent[i].rdy1 && jmp_wake_valid && (jmp_wake_prd == ent[i].prs1);
            m1w[i] = ent[i].p1v && !ent[i].rdy1 && wb_wake_valid  && (wb_wake_prd  == ent[i].prs1);
            m2a[i] = ent[i].p2v && !ent[i].rdy2 && alu_wake_valid && (alu_wake_prd == ent[i].prs2);
            m2j[i] = ent[i].p2v && !ent[i].rdy2 && jmp_wake_valid && (jmp_wake_prd == ent[i].prs2);
            m2w[i] = ent[i].p2v && !ent[i].rdy2 && wb_wake_valid  && (wb_wake_prd  == ent[i].prs2);
            elig[i] = vld[i] && (ent[i].rdy1 || m1a[i] || m1j[i] || m1w[i])
                             && (ent[i].rdy2 || m2a[i] || m2j[i] || m2w[i]);
        end
    end

    // Descending scan leaves the lowest eligible index (oldest) in sel.
    always_comb begin
        any_elig = 1'b0;
        sel      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                any_elig = 1'b1;
                sel      = IW'(i);
            end
        end
    end

    assign s_ent            = ent[sel];
    assign req_issue        = any_elig && !flush_iq;
    assign pos_issue        = s_ent.pos;
    assign prd_issue        = s_ent.prd;
    assign prs1_issue       = s_ent.prs1;
    assign prs2_issue       = s_ent.prs2;
    assign prs1_valid_issue = s_ent.p1v;
    assign prs2_valid_issue = s_ent.p2v;
    assign funct3_issue     = s_ent.funct3;
    assign funct7_issue     = s_ent.funct7;
    assign rs1_issue        = s_ent.rs1;
    assign rs2_issue        = s_ent.rs2;
    assign rd_issue         = s_ent.rd;
    assign pc_issue         = s_ent.pc;
    // ALU wins if a duplicate prd matches both bypassable broadcasts.
    assign alubypass1_issue = req_issue && m1a[sel];
    assign alubypass2_issue = req_issue && m2a[sel];
    assign jmpbypass1_issue = req_issue && m1j[sel] && !m1a[sel];
    assign jmpbypass2_issue = req_issue && m2j[sel] && !m2a[sel];

    assign dispatch_ready = (count < CW'(DEPTH));
    assign accept         = dispatch_valid && dispatch_ready && !flush_iq;
    assign cnt_rm         = count - CW'(req_issue);
    assign count_n        = cnt_rm + CW'(accept);
    assign iq_count       = count;

    always_comb begin
        new_e        = '0;
        new_e.pos    = dispatch_pos;
        new_e.prd    = dispatch_prd;
        new_e.prs1   = dispatch_prs1;
        new_e.prs2   = dispatch_prs2;
        new_e.p1v    = dispatch_prs1_valid;
        new_e.p2v    = dispatch_prs2_valid;
        new_e.funct3 = dispatch_funct3;
        new_e.funct7 = dispatch_funct7;
        new_e.rs1    = dispatch_rs1;
        new_e.rs2    = dispatch_rs2;
        new_e.rd     = dispatch_rd;
        new_e.pc     = dispatch_pc;
        new_e.rdy1   = !dispatch_prs1_valid || dispatch_prs1_ready
                     || (alu_wake_valid && alu_wake_prd == dispatch_prs1)
                     || (jmp_wake_valid && jmp_wake_prd == dispatch_prs1)
                     || (wb_wake_valid  && wb_wake_prd  == dispatch_prs1);
        new_e.rdy2   = !dispatch_prs2_valid || dispatch_prs2_ready
                     || (alu_wake_valid && alu_wake_prd == dispatch_prs2)
                     || (jmp_wake_valid && jmp_wake_prd == dispatch_prs2)
                     || (wb_wake_valid  && wb_wake_prd  == dispatch_prs2);
    end

    // Apply wakeups, collapse over the issued slot, then append the dispatch.
    always_comb begin
        vld_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            upd[i]      = ent[i];
            upd[i].rdy1 = ent[i].rdy1 || m1a[i] || m1j[i] || m1w[i];
            upd[i].rdy2 = ent[i].rdy2 || m2a[i] || m2j[i] || m2w[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            int j;
            j = (req_issue && i >= int'(sel)) ? i + 1 : i;
            if (j < DEPTH) begin
                vld_n[i] = vld[j];
                ent_n[i] = upd[j];
            end else begin
                vld_n[i] = 1'b0;
                ent_n[i] = upd[i];
            end
            if (accept && CW'(i) == cnt_rm) begin
                vld_n[i] = 1'b1;
                ent_n[i] = new_e;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_iq) begin
            vld   <= '0;
            count <= '0;
        end else begin
            vld   <= vld_n;
            count <= count_n;
        end
    end

    always_ff @(posedge clk) begin
        ent <= ent_n;
    end

`ifdef JMP_IQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            issued_cnt   <= '0;
        end else begin
            if (count != '0 && !req_issue && !flush_iq)
                stall_cycles <= stall_cycles + 32'd1;
            if (req_issue)
                issued_cnt <= issued_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jmp_issue_queue.sv
// tb/tb_jmp_issue_queue.sv - cycle-vector self-checking bench for jmp_issue_queue
module tb_jmp_issue_queue;

    logic        clk = 1'b0;
    logic        reset, flush_iq, dispatch_valid, dispatch_ready;
    logic [5:0]  dispatch_pos, dispatch_prd, dispatch_prs1, dispatch_prs2;
    logic        dispatch_prs1_valid, dispatch_prs2_valid, dispatch_prs1_ready, dispatch_prs2_ready;
    logic [2:0]  dispatch_funct3;
    logic [6:0]  dispatch_funct7;
    logic [4:0]  dispatch_rs1, dispatch_rs2, dispatch_rd;
    logic [31:0] dispatch_pc;
    logic        alu_wake_valid, jmp_wake_valid, wb_wake_valid;
    logic [5:0]  alu_wake_prd, jmp_wake_prd, wb_wake_prd;
    logic        req_issue;
    logic [5:0]  pos_issue, prd_issue, prs1_issue, prs2_issue;
    logic        prs1_valid_issue, prs2_valid_issue;
    logic [2:0]  funct3_issue;
    logic [6:0]  funct7_issue;
    logic [4:0]  rs1_issue, rs2_issue, rd_issue;
    logic [31:0] pc_issue;
    logic        alubypass1_issue, alubypass2_issue, jmpbypass1_issue, jmpbypass2_issue;
    logic [2:0]  iq_count;

    jmp_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush_iq(flush_iq),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_pos(dispatch_pos), .dispatch_prd(dispatch_prd),
        .dispatch_prs1(dispatch_prs1), .dispatch_prs2(dispatch_prs2),
        .dispatch_prs1_valid(dispatch_prs1_valid), .dispatch_prs2_valid(dispatch_prs2_valid),
        .dispatch_prs1_ready(dispatch_prs1_ready), .dispatch_prs2_ready(dispatch_prs2_ready),
        .dispatch_funct3(dispatch_funct3), .dispatch_funct7(dispatch_funct7),
        .dispatch_rs1(dispatch_rs1), .dispatch_rs2(dispatch_rs2), .dispatch_rd(dispatch_rd),
        .dispatch_pc(dispatch_pc),
        .alu_wake_valid(alu_wake_valid), .alu_wake_prd(alu_wake_prd),
        .jmp_wake_valid(jmp_wake_valid), .jmp_wake_prd(jmp_wake_prd),
        .wb_wake_valid(wb_wake_valid), .wb_wake_prd(wb_wake_prd),
        .req_issue(req_issue), .pos_issue(pos_issue), .prd_issue(prd_issue),
        .prs1_issue(prs1_issue), .prs2_issue(prs2_issue),
        .prs1_valid_issue(prs1_valid_issue), .prs2_valid_issue(prs2_valid_issue),
        .funct3_issue(funct3_issue), .funct7_issue(funct7_issue),
        .rs1_issue(rs1_issue), .rs2_issue(rs2_issue), .rd_issue(rd_issue),
        .pc_issue(pc_issue),
        .alubypass1_issue(alubypass1_issue), .alubypass2_issue(alubypass2_issue),
        .jmpbypass1_issue(jmpbypass1_issue), .jmpbypass2_issue(jmpbypass2_issue),
        .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    // One record per cycle; s1/s2: 0 unused, 1 waiting, 2 ready.
    // wk: 0 none, 1 alu, 2 jmp, 3 wb, 4 alu+jmp. byp = {ab1, ab2, jb1, jb2}.
    typedef struct {
        logic       fl;
        logic       dv;
        logic [5:0] pos;
        logic [5:0] prs1;
        int         s1;
        logic [5:0] prs2;
        int         s2;
        int         wk;
        logic [5:0] wprd;
        logic       e_req;
        logic [5:0] e_pos;
        logic [3:0] e_byp;
        logic       e_dr;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    function automatic logic [31:0] pcf(input logic [5:0] p);
        return (p == 6'd5) ? 32'h100 : 32'h1000 + 32'(p) * 32'd4;
    endfunction

    function automatic vec_t mk(input logic fl, input logic dv, input logic [5:0] pos,
                                input logic [5:0] prs1, input int s1, input logic [5:0] prs2,
                                input int s2, input int wk, input logic [5:0] wprd,
                                input logic e_req, input logic [5:0] e_pos, input logic [3:0] e_byp,
                                input logic e_dr, input logic [2:0] e_cnt);
        vec_t v;
        v.fl = fl; v.dv = dv; v.pos = pos; v.prs1 = prs1; v.s1 = s1; v.prs2 = prs2; v.s2 = s2;
        v.wk = wk; v.wprd = wprd; v.e_req = e_req; v.e_pos = e_pos; v.e_byp = e_byp;
        v.e_dr = e_dr; v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic vec_t idle(input logic e_req, input logic [5:0] e_pos,
                                  input logic [3:0] e_byp, input logic e_dr, input logic [2:0] e_cnt);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e_req, e_pos, e_byp, e_dr, e_cnt);
    endfunction

    task automatic drive(input vec_t v);
        flush_iq            = v.fl;
        dispatch_valid      = v.dv;
        dispatch_pos        = v.pos;
        dispatch_prd        = v.pos + 6'd32;
        dispatch_prs1       = v.prs1;
        dispatch_prs2       = v.prs2;
        dispatch_prs1_valid = (v.s1 != 0);
        dispatch_prs1_ready = (v.s1 == 2);
        dispatch_prs2_valid = (v.s2 != 0);
        dispatch_prs2_ready = (v.s2 == 2);
        dispatch_funct3     = 3'd1;
        dispatch_funct7     = 7'd0;
        dispatch_rs1        = 5'd1;
        dispatch_rs2        = 5'd2;
        dispatch_rd         = 5'd3;
        dispatch_pc         = pcf(v.pos);
        alu_wake_valid      = (v.wk == 1 || v.wk == 4);
        jmp_wake_valid      = (v.wk == 2 || v.wk == 4);
        wb_wake_valid       = (v.wk == 3);
        alu_wake_prd        = v.wprd;
        jmp_wake_prd        = v.wprd;
        wb_wake_prd         = v.wprd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " req_issue"}, 32'(req_issue), 32'(v.e_req));
        check({tag, " dispatch_ready"}, 32'(dispatch_ready), 32'(v.e_dr));
        check({tag, " iq_count"}, 32'(iq_count), 32'(v.e_cnt));
        check({tag, " bypass"}, 32'({alubypass1_issue, alubypass2_issue, jmpbypass1_issue, jmpbypass2_issue}),
              32'(v.e_byp));
        if (v.e_req) begin
            check({tag, " pos_issue"}, 32'(pos_issue), 32'(v.e_pos));
            check({tag, " pc_issue"}, pc_issue, pcf(v.e_pos));
            check({tag, " prd_issue"}, 32'(prd_issue), 32'(v.e_pos + 6'd32));
        end
    endtask

    initial begin
        // reset state
        vecs.push_back(idle(0, 0, 4'b0000, 1, 0));
        // JAL with no sources issues the cycle after dispatch
        vecs.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(idle(1, 5, 4'b0000, 1, 1));
        vecs.push_back(idle(0, 0, 4'b0000, 1, 0));
        // branch waiting on prs1=12, woken by ALU two cycles later
        vecs.push_back(mk(0, 1, 6, 12, 1, 13, 2, 0, 0, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(idle(0, 0, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 1, 6, 4'b1000, 1, 1));
        vecs.push_back(idle(0, 0, 4'b0000, 1, 0));
        // fill with four entries waiting on prs 20; dispatch while full is refused
        vecs.push_back(mk(0, 1, 1, 20, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 1, 2, 20, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 1, 3, 20, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 1, 4, 20, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 3));
        vecs.push_back(mk(0, 1, 9, 0, 0, 0, 0, 2, 20, 1, 1, 4'b0010, 0, 4));
        vecs.push_back(idle(1, 2, 4'b0000, 1, 3));
        vecs.push_back(idle(1, 3, 4'b0000, 1, 2));
        vecs.push_back(idle(1, 4, 4'b0000, 1, 1));
        vecs.push_back(idle(0, 0, 4'b0000, 1, 0));
        // younger ready entry issues past older waiters; same-cycle dispatch appends
        vecs.push_back(mk(0, 1, 10, 30, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 1, 11, 31, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 1, 12, 0, 0, 0, 0, 0, 0, 1, 7, 4'b0000, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 31, 1, 11, 4'b1000, 1, 3));
        vecs.push_back(idle(1, 12, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 30, 1, 10, 4'b0000, 1, 1));
        vecs.push_back(idle(0, 0, 4'b0000, 1, 0));
        // flush with three entries and a concurrent dispatch
        vecs.push_back(mk(0, 1, 13, 40, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 1, 14, 40, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 2));
        vecs.push_back(mk(1, 1, 16, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 3));
        vecs.push_back(idle(0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 40, 0, 0, 4'b0000, 1, 0));
        // wb wakeup in the dispatch cycle: ready next cycle, no bypass
        vecs.push_back(mk(0, 1, 17, 9, 1, 0, 0, 3, 9, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(idle(1, 17, 4'b0000, 1, 1));
        vecs.push_back(idle(0, 0, 4'b0000, 1, 0));
        // duplicate ALU+JMP match on source 2: ALU bypass wins
        vecs.push_back(mk(0, 1, 18, 0, 0, 50, 1, 0, 0, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(idle(0, 0, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 50, 1, 18, 4'b0100, 1, 1));
        vecs.push_back(idle(0, 0, 4'b0000, 1, 0));

        reset = 1'b1;
        drive(idle(0, 0, 4'b0000, 1, 0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", k), vecs[k]);
            @(posedge clk);
            #1;
        end

        // reset asserted mid-operation discards entries like a flush
        drive(mk(0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
        @(posedge clk);
        #1 drive(mk(0, 1, 21, 22, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
        reset = 1'b1;
        @(negedge clk);
        check("midreset pre count", 32'(iq_count), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(idle(0, 0, 4'b0000, 1, 0));
        @(negedge clk);
        check_outputs("midreset post", idle(0, 0, 4'b0000, 1, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
